clk_div_bank: RTL and testbench
===============================

Name: clk_div_bank

Overview:
- Parametrised, multi-channel successor to the fixed three-output clock divider.
- NUM_CH independent channels, each with a runtime-programmable terminal count, per-channel enable, square-wave output and single-cycle tick strobe.
- Terminal counts are reconfigured through a valid/ready port, and a global restart phase-aligns all channels.
- Sits between the board oscillator and the counter/display logic (unit, fast-refresh and blink rates).

Parameters:
- NUM_CH, 3, number of divider channels (1..8).
- CNT_W, 27, counter and terminal-count width in bits.
- DIV_INIT, {27'd49999999, 27'd300000, 27'd50000000}, packed NUM_CH*CNT_W reset terminal counts; channel i uses bits [i*CNT_W +: CNT_W].

Ports:
- internal_clk  in  1  sole clock; all logic is posedge.
- rst_n  in  1  synchronous reset, active-low.
- ch_en  in  NUM_CH  per-channel count enable.
- sync_restart  in  1  zeroes all counters and clk_out on the next edge.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration port can accept.
- cfg_ch  in  3  target channel index.
- cfg_div  in  CNT_W  new terminal count.
- cfg_restart  in  1  apply immediately and restart the channel (otherwise apply at the next wrap).
- cfg_err  out  1  one-cycle pulse on an accepted request with cfg_ch >= NUM_CH.
- clk_out  out  NUM_CH  divided square waves.
- tick  out  NUM_CH  one-cycle pulse on every clk_out toggle.

Behaviour:
- Reset (rst_n=0 sampled at posedge): cnt[i]=0, tc[i]=DIV_INIT slice, pend[i]=0, clk_out=0, tick=0, cfg_ready=0, cfg_err=0, config stage empty.
- cfg_ready goes to 1 on the first edge with rst_n=1.
- Channel step, when ch_en[i]=1:
  - cnt[i]==tc[i]: cnt<=0, clk_out[i] toggles, tick[i]=1 for that cycle. If pend[i]: tc[i]<=shadow[i], pend[i]<=0.
  - Otherwise cnt<=cnt+1, tick[i]=0.
- Output period is 2*(tc+1) cycles, 50% duty. tc=0 toggles clk_out every cycle (divide by 2).
- ch_en[i]=0: cnt, clk_out and tc hold; tick=0; pend is retained.
- sync_restart=1: all cnt<=0, clk_out<=0, tick<=0 on that edge. It overrides wraps and enables, and pending shadows stay pending.
- Config handshake:
  - Transfer when cfg_valid & cfg_ready at edge t. Fields are registered in a one-entry stage, and cfg_ready=0 in cycle t+1.
  - The stage is applied at edge t+1, and cfg_ready returns to 1 at t+2. Max throughput is one transfer per 2 cycles.
  - Apply with cfg_restart=0: shadow[ch]<=cfg_div, pend[ch]<=1; a later write before the wrap overwrites it (last write wins).
  - Apply with cfg_restart=1: tc[ch]<=cfg_div, cnt[ch]<=0, clk_out[ch]<=0, pend[ch]<=0, no tick.
  - Invalid channel: no state change, cfg_err=1 during cycle t+1.
- Apply vs. channel wrap on the same edge:
  - restart apply wins: counter=0, clk_out=0, no toggle.
  - deferred apply: wrap completes with the old tc, and the new value goes pending for the next wrap.
- Apply vs. sync_restart on the same edge: both take effect, and the new tc is loaded if cfg_restart=1.
- cfg_div is an unsigned full-width value; the counter never exceeds tc. If a restart lowers tc below cnt, the zeroed counter prevents overflow.
- Reset mid-transfer discards the stage and all pending shadows.
- cfg_ch bits above log2(NUM_CH) participate in the invalid check.

Optional Feature:
- Macro: CLK_DIV_BANK_PAUSE_EN.
- Defined:
  - Adds input pause (1 bit). While pause=1, all counters, clk_out and pend hold, and tick=0.
  - sync_restart and config applies still act. A restart apply zeroes the channel, which resumes from zero after pause.
- Undefined: no pause port; channels run whenever ch_en is set.

Test Plan:
- Reset, then NUM_CH=3 with DIV_INIT ch1=300000 and all ch_en=1 -> clk_out[1] first toggles 300001 cycles after reset release; tick[1] is a single cycle each time; cfg_ready=1 on the first post-reset edge.
- Override ch0 with cfg_div=3, cfg_restart=1 -> clk_out[0] period 8 cycles, 4 high / 4 low; ticks exactly every 4 cycles.
- ch0 tc=3 running, write cfg_div=1 with cfg_restart=0 -> old 4-cycle half-period finishes, then half-period 2; cfg_ready low exactly one cycle after the accept.
- Write cfg_ch=5 -> cfg_err high for 1 cycle, no tc/clk_out change on any channel.
- ch2 clk_out=1 mid-period, assert sync_restart with ch_en=3'b101 -> all clk_out=0 and cnt=0 next edge; ch1 stays frozen until its enable returns.
- Assert rst_n=0 one cycle after a deferred write -> tc returns to DIV_INIT, pend cleared, no late apply after release.

Source files
------------

// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CH independent programmable clock dividers sharing one
// oscillator. Each channel counts 0..tc, toggles its square wave and pulses
// tick on every wrap, so the output period is 2*(tc+1) cycles.
// Terminal counts are reprogrammed through a one-entry config stage, either
// immediately (with a channel restart) or deferred to the channel's next wrap.
// A global sync_restart phase-aligns all channels.
//
// Optional build macro: CLK_DIV_BANK_PAUSE_EN adds a 'pause' input that
// freezes every channel while high. Config applies and sync_restart still act.
module clk_div_bank #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 27,
    parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {27'd49999999, 27'd300000, 27'd50000000}
) (
    input  logic                internal_clk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic                sync_restart,
`ifdef CLK_DIV_BANK_PAUSE_EN
    input  logic                pause,
`endif
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [2:0]          cfg_ch,
    input  logic [CNT_W-1:0]    cfg_div,
    input  logic                cfg_restart,
    output logic                cfg_err,
    output logic [NUM_CH-1:0]   clk_out,
    output logic [NUM_CH-1:0]   tick
);

    // Channel indices are compared on all three cfg_ch bits, so aliases such
    // as 5 on a 3-channel build are rejected rather than folded onto ch1.
    localparam logic [3:0] NUM_CH_W = 4'(NUM_CH);

    // ------------------------------------------------------------------
    // Config handshake: a request transfers on a rising edge where
    // cfg_valid and cfg_ready are both 1. The fields land in a one-entry
    // stage and cfg_ready drops for exactly one cycle while the stage is
    // applied on the following edge, so at most one transfer per 2 cycles.
    // cfg_valid may be held while cfg_ready is low; nothing is lost.
    // ------------------------------------------------------------------
    logic               accept;
    logic               ch_bad;
    logic               cfg_ready_q, cfg_ready_d;
    logic               cfg_err_q,   cfg_err_d;
    logic               stg_valid_q, stg_valid_d;
    logic [2:0]         stg_ch_q,    stg_ch_d;
    logic [CNT_W-1:0]   stg_div_q,   stg_div_d;
    logic               stg_restart_q, stg_restart_d;

    // Per-channel divider state
    logic [CNT_W-1:0]   cnt_q    [NUM_CH];
    logic [CNT_W-1:0]   cnt_d    [NUM_CH];
    logic [CNT_W-1:0]   tc_q     [NUM_CH];
    logic [CNT_W-1:0]   tc_d     [NUM_CH];
    logic [CNT_W-1:0]   shadow_q [NUM_CH];
    logic [CNT_W-1:0]   shadow_d [NUM_CH];
    logic [NUM_CH-1:0]  pend_q,  pend_d;
    logic [NUM_CH-1:0]  clk_q,   clk_d;
    logic [NUM_CH-1:0]  tick_q,  tick_d;

    // Global run qualifier: pause (when built in) stops counting only.
    logic               run_en;
`ifdef CLK_DIV_BANK_PAUSE_EN
    assign run_en = ~pause;
`else
    assign run_en = 1'b1;
`endif

    // Config stage next-state: capture on accept, flag bad channels, and
    // hold ready low for the single apply cycle.
    always_comb begin
        accept        = cfg_valid & cfg_ready_q;
        ch_bad        = ({1'b0, cfg_ch} >= NUM_CH_W);
        cfg_ready_d   = ~accept;
        cfg_err_d     = accept & ch_bad;
        stg_valid_d   = accept & ~ch_bad;
        stg_ch_d      = stg_ch_q;
        stg_div_d     = stg_div_q;
        stg_restart_d = stg_restart_q;
        if (accept) begin
            stg_ch_d      = cfg_ch;
            stg_div_d     = cfg_div;
            stg_restart_d = cfg_restart;
        end
    end

    // Config stage registers; reset empties the stage and drops ready.
    always_ff @(posedge internal_clk) begin
        if (!rst_n) begin
            cfg_ready_q   <= 1'b0;
            cfg_err_q     <= 1'b0;
            stg_valid_q   <= 1'b0;
            stg_ch_q      <= '0;
            stg_div_q     <= '0;
            stg_restart_q <= 1'b0;
        end else begin
            cfg_ready_q   <= cfg_ready_d;
            cfg_err_q     <= cfg_err_d;
            stg_valid_q   <= stg_valid_d;
            stg_ch_q      <= stg_ch_d;
            stg_div_q     <= stg_div_d;
            stg_restart_q <= stg_restart_d;
        end
    end

    // Channel next-state. Priority, lowest to highest:
    //   count/wrap -> sync_restart (suppresses the wrap, keeps pend) ->
    //   staged apply. A restart apply zeroes the channel and cancels any
    //   tick; a deferred apply on a wrap edge lets the wrap use the old
    //   shadow and leaves the new value pending for the next wrap.
    always_comb begin
        cnt_d    = cnt_q;
        tc_d     = tc_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        clk_d    = clk_q;
        tick_d   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sync_restart) begin
                cnt_d[i] = '0;
                clk_d[i] = 1'b0;
            end else if (ch_en[i] && run_en) begin
                if (cnt_q[i] == tc_q[i]) begin
                    cnt_d[i]  = '0;
                    clk_d[i]  = ~clk_q[i];
                    tick_d[i] = 1'b1;
                    if (pend_q[i]) begin
                        tc_d[i]   = shadow_q[i];
                        pend_d[i] = 1'b0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
            if (stg_valid_q && (stg_ch_q == 3'(i))) begin
                if (stg_restart_q) begin
                    tc_d[i]   = stg_div_q;
                    cnt_d[i]  = '0;
                    clk_d[i]  = 1'b0;
                    pend_d[i] = 1'b0;
                    tick_d[i] = 1'b0;
                end else begin
                    shadow_d[i] = stg_div_q;
                    pend_d[i]   = 1'b1;
                end
            end
        end
    end

    // Channel registers; reset reloads the build-time terminal counts and
    // discards any pending shadow value.
    always_ff @(posedge internal_clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]    <= '0;
                tc_q[i]     <= DIV_INIT[i*CNT_W +: CNT_W];
                shadow_q[i] <= '0;
            end
            pend_q <= '0;
            clk_q  <= '0;
            tick_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]    <= cnt_d[i];
                tc_q[i]     <= tc_d[i];
                shadow_q[i] <= shadow_d[i];
            end
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign cfg_err   = cfg_err_q;
    assign clk_out   = clk_q;
    assign tick      = tick_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank. Built with scaled reset terminal counts
// (ch0=20, ch1=300, ch2=6) so the reset-release scenario stays short.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_clk_div_bank;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 27;
    localparam logic [NUM_CH*CNT_W-1:0] DIV_INIT_TB = {27'd6, 27'd300, 27'd20};

    logic              internal_clk;
    logic              rst_n;
    logic [NUM_CH-1:0] ch_en;
    logic              sync_restart;
`ifdef CLK_DIV_BANK_PAUSE_EN
    logic              pause;
`endif
    logic              cfg_valid;
    logic              cfg_ready;
    logic [2:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_restart;
    logic              cfg_err;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    int total;
    int bad;

    clk_div_bank #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .DIV_INIT (DIV_INIT_TB)
    ) dut (
        .internal_clk (internal_clk),
        .rst_n        (rst_n),
        .ch_en        (ch_en),
        .sync_restart (sync_restart),
`ifdef CLK_DIV_BANK_PAUSE_EN
        .pause        (pause),
`endif
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_div      (cfg_div),
        .cfg_restart  (cfg_restart),
        .cfg_err      (cfg_err),
        .clk_out      (clk_out),
        .tick         (tick)
    );

    // clock
    initial internal_clk = 1'b0;
    always #5 internal_clk = ~internal_clk;

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge internal_clk);
    endtask

    // Issue one config request; returns on the falling edge after the
    // accepting rising edge (stage full, apply on the next rising edge).
    task automatic write_cfg(input logic [2:0] ch, input logic [CNT_W-1:0] div, input logic rs);
        bit done;
        done        = 1'b0;
        cfg_ch      = ch;
        cfg_div     = div;
        cfg_restart = rs;
        cfg_valid   = 1'b1;
        for (int n = 0; n < 10 && !done; n++) begin
            if (cfg_ready) begin
                @(posedge internal_clk);
                done = 1'b1;
            end else begin
                @(negedge internal_clk);
            end
        end
        @(negedge internal_clk);
        cfg_valid = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL cfg_accept: ready never seen, got 0 expected 1");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        total++; if (clk_out !== 3'b000) begin bad++; $display("FAIL rst_clk_out: got %b expected 000", clk_out); end
        total++; if (tick !== 3'b000) begin bad++; $display("FAIL rst_tick: got %b expected 000", tick); end
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL rst_cfg_ready: got %b expected 0", cfg_ready); end
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL rst_cfg_err: got %b expected 0", cfg_err); end
        rst_n = 1'b1;
        for (int k = 1; k <= 302; k++) begin
            step();
            if (k == 1) begin
                total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL rel_cfg_ready: got %b expected 1", cfg_ready); end
            end
            if (k == 6) begin
                total++; if (clk_out[2] !== 1'b0) begin bad++; $display("FAIL rel_ch2_early: got %b expected 0", clk_out[2]); end
            end
            if (k == 7) begin
                total++; if ({clk_out[2], tick[2]} !== 2'b11) begin bad++; $display("FAIL rel_ch2_toggle: got %b expected 11", {clk_out[2], tick[2]}); end
            end
            if (k == 14) begin
                total++; if (clk_out[2] !== 1'b0) begin bad++; $display("FAIL rel_ch2_second: got %b expected 0", clk_out[2]); end
            end
            if (k == 21) begin
                total++; if ({clk_out[0], tick[0]} !== 2'b11) begin bad++; $display("FAIL rel_ch0_toggle: got %b expected 11", {clk_out[0], tick[0]}); end
            end
            if (k == 300) begin
                total++; if ({clk_out[1], tick[1]} !== 2'b00) begin bad++; $display("FAIL rel_ch1_early: got %b expected 00", {clk_out[1], tick[1]}); end
            end
            if (k == 301) begin
                total++; if ({clk_out[1], tick[1]} !== 2'b11) begin bad++; $display("FAIL rel_ch1_toggle: got %b expected 11", {clk_out[1], tick[1]}); end
            end
            if (k == 302) begin
                total++; if ({clk_out[1], tick[1]} !== 2'b10) begin bad++; $display("FAIL rel_ch1_tick_width: got %b expected 10", {clk_out[1], tick[1]}); end
            end
        end
    endtask

    task automatic test_restart_override();
        logic exp_clk, exp_tick;
        write_cfg(3'd0, 27'd3, 1'b1);
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL ovr_ready_low: got %b expected 0", cfg_ready); end
        step();
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL ovr_ready_back: got %b expected 1", cfg_ready); end
        total++; if ({clk_out[0], tick[0]} !== 2'b00) begin bad++; $display("FAIL ovr_apply: got %b expected 00", {clk_out[0], tick[0]}); end
        for (int j = 1; j <= 16; j++) begin
            step();
            exp_clk  = ((j / 4) % 2) == 1;
            exp_tick = (j % 4) == 0;
            total++; if (clk_out[0] !== exp_clk) begin bad++; $display("FAIL ovr_clk j=%0d: got %b expected %b", j, clk_out[0], exp_clk); end
            total++; if (tick[0] !== exp_tick) begin bad++; $display("FAIL ovr_tick j=%0d: got %b expected %b", j, tick[0], exp_tick); end
        end
    endtask

    task automatic test_deferred();
        logic exp_clk, exp_tick;
        write_cfg(3'd0, 27'd3, 1'b1);   // accept s1, ch0 zeroed at s2
        write_cfg(3'd0, 27'd1, 1'b0);   // accept s3, pending from s4
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL def_ready_low: got %b expected 0", cfg_ready); end
        total++; if (clk_out[0] !== 1'b0) begin bad++; $display("FAIL def_clk_s3: got %b expected 0", clk_out[0]); end
        for (int s = 4; s <= 13; s++) begin
            step();
            if (s == 4) begin
                total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL def_ready_back: got %b expected 1", cfg_ready); end
            end
            exp_clk  = (s >= 6) && (((s - 6) / 2) % 2 == 0);
            exp_tick = (s >= 6) && (s % 2 == 0);
            total++; if (clk_out[0] !== exp_clk) begin bad++; $display("FAIL def_clk s=%0d: got %b expected %b", s, clk_out[0], exp_clk); end
            total++; if (tick[0] !== exp_tick) begin bad++; $display("FAIL def_tick s=%0d: got %b expected %b", s, tick[0], exp_tick); end
        end
    endtask

    task automatic test_invalid_ch();
        ch_en = 3'b111;
        write_cfg(3'd0, 27'd1, 1'b1);   // ch0 zeroed at s2, tc=1
        write_cfg(3'd1, 27'd0, 1'b1);   // accept s3, ch1 zeroed at s4, tc=0
        step();                          // s4
        step();                          // s5: ch0 high (cnt 1), ch1 high (cnt 0)
        total++; if (clk_out[1:0] !== 2'b11) begin bad++; $display("FAIL inv_setup: got %b expected 11", clk_out[1:0]); end
        ch_en = 3'b000;
        write_cfg(3'd5, 27'd2, 1'b1);   // accept s6
        total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL inv_err_pulse: got %b expected 1", cfg_err); end
        total++; if (clk_out[1:0] !== 2'b11) begin bad++; $display("FAIL inv_hold_s6: got %b expected 11", clk_out[1:0]); end
        step();                          // s7: stage slot passed
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL inv_err_width: got %b expected 0", cfg_err); end
        total++; if (clk_out[1:0] !== 2'b11) begin bad++; $display("FAIL inv_hold_s7: got %b expected 11", clk_out[1:0]); end
        total++; if (tick !== 3'b000) begin bad++; $display("FAIL inv_tick_idle: got %b expected 000", tick); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL inv_ready: got %b expected 1", cfg_ready); end
        ch_en = 3'b011;
        step();                          // s8: both wrap with unchanged tc
        total++; if ({clk_out[1:0], tick[1:0]} !== 4'b0011) begin bad++; $display("FAIL inv_resume_s8: got %b expected 0011", {clk_out[1:0], tick[1:0]}); end
        step();                          // s9: ch1 (tc=0) toggles again, ch0 counts
        total++; if ({clk_out[1:0], tick[1:0]} !== 4'b1010) begin bad++; $display("FAIL inv_resume_s9: got %b expected 1010", {clk_out[1:0], tick[1:0]}); end
    endtask

    task automatic test_sync_restart();
        ch_en = 3'b111;
        write_cfg(3'd2, 27'd3, 1'b1);   // accept s1, ch2 zeroed at s2
        for (int s = 2; s <= 7; s++) begin
            step();
            if (s == 6) ch_en = 3'b101;  // freeze ch1 while it is high
        end
        total++; if (clk_out[2:1] !== 2'b11) begin bad++; $display("FAIL sr_setup: got %b expected 11", clk_out[2:1]); end
        sync_restart = 1'b1;
        step();                          // s8
        sync_restart = 1'b0;
        total++; if (clk_out !== 3'b000) begin bad++; $display("FAIL sr_clk_zero: got %b expected 000", clk_out); end
        total++; if (tick !== 3'b000) begin bad++; $display("FAIL sr_tick_zero: got %b expected 000", tick); end
        for (int s = 9; s <= 12; s++) begin
            step();
            total++; if ({clk_out[1], tick[1]} !== 2'b00) begin bad++; $display("FAIL sr_ch1_frozen s=%0d: got %b expected 00", s, {clk_out[1], tick[1]}); end
            if (s == 10) begin
                total++; if ({clk_out[0], tick[0]} !== 2'b11) begin bad++; $display("FAIL sr_ch0_phase: got %b expected 11", {clk_out[0], tick[0]}); end
            end
            if (s == 11) begin
                total++; if (clk_out[2] !== 1'b0) begin bad++; $display("FAIL sr_ch2_early: got %b expected 0", clk_out[2]); end
            end
            if (s == 12) begin
                total++; if ({clk_out[2], tick[2]} !== 2'b11) begin bad++; $display("FAIL sr_ch2_phase: got %b expected 11", {clk_out[2], tick[2]}); end
            end
        end
        ch_en = 3'b111;
        step();                          // s13: ch1 resumes from zero, tc=0
        total++; if ({clk_out[1], tick[1]} !== 2'b11) begin bad++; $display("FAIL sr_ch1_resume: got %b expected 11", {clk_out[1], tick[1]}); end
    endtask

    task automatic test_reset_pending();
        logic exp_clk, exp_tick;
        write_cfg(3'd2, 27'd0, 1'b0);   // deferred write to ch2
        step();                          // pending now set
        rst_n = 1'b0;
        step();
        total++; if (clk_out !== 3'b000) begin bad++; $display("FAIL rp_clk: got %b expected 000", clk_out); end
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL rp_ready: got %b expected 0", cfg_ready); end
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (k == 1) begin
                total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL rp_ready_rel: got %b expected 1", cfg_ready); end
            end
            exp_clk  = (k >= 7) && (k < 14);
            exp_tick = (k == 7) || (k == 14);
            total++; if (clk_out[2] !== exp_clk) begin bad++; $display("FAIL rp_ch2_clk k=%0d: got %b expected %b", k, clk_out[2], exp_clk); end
            total++; if (tick[2] !== exp_tick) begin bad++; $display("FAIL rp_ch2_tick k=%0d: got %b expected %b", k, tick[2], exp_tick); end
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        ch_en        = 3'b111;
        sync_restart = 1'b0;
`ifdef CLK_DIV_BANK_PAUSE_EN
        pause        = 1'b0;
`endif
        cfg_valid    = 1'b0;
        cfg_ch       = 3'd0;
        cfg_div      = '0;
        cfg_restart  = 1'b0;
        step();
        test_reset();
        test_restart_override();
        test_deferred();
        test_invalid_ch();
        test_sync_restart();
        test_reset_pending();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
